// File: rtl/sram_scan_pkg.sv
// Shared types and header/word geometry for the serial-scan SRAM burst controller.
// SRAM_SCAN_PARITY_EN adds one even-parity bit per data word in both directions.
package sram_scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_WR_SHIFT,
        ST_WR_ISSUE,
        ST_RD_ISSUE,
        ST_RD_SHIFT,
        ST_DONE
    } state_e;

`ifdef SRAM_SCAN_PARITY_EN
    localparam int unsigned PAR_BITS = 1;
`else
    localparam int unsigned PAR_BITS = 0;
`endif

    localparam int unsigned HDR_RW_BIT  = 0;
    localparam int unsigned HDR_CNT_LSB = 1;

    function automatic int unsigned hdr_addr_lsb(input int unsigned cnt_w);
        return 1 + cnt_w;
    endfunction

    function automatic int unsigned hdr_len(input int unsigned addr_w, input int unsigned cnt_w);
        return 1 + cnt_w + addr_w;
    endfunction

    function automatic int unsigned word_bits(input int unsigned data_w);
        return data_w + PAR_BITS;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sram_scan_burst_ctrl_if.sv
// Scan-pin and SRAM-port bundle for sram_scan_burst_ctrl.
// slave = controller side, master = scan host / SRAM side.
interface sram_scan_burst_ctrl_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 8
);
    logic              scan_en;
    logic              scan_in;
    logic              scan_out;
    logic              scan_out_valid;
    logic              busy;
    logic              done;
    logic              err;
    logic              sram_ce;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_din;
    logic [DATA_W-1:0] sram_dout;

    modport slave (
        input  scan_en, scan_in, sram_dout,
        output scan_out, scan_out_valid, busy, done, err,
               sram_ce, sram_we, sram_addr, sram_din
    );

    modport master (
        output scan_en, scan_in, sram_dout,
        input  scan_out, scan_out_valid, busy, done, err,
               sram_ce, sram_we, sram_addr, sram_din
    );
endinterface

// File: rtl/sram_scan_shift.sv
// Right-shifting register (serial in at MSB, serial out at LSB) with parallel
// load, synchronous clear and a count of bits shifted since the last clear/load.
module sram_scan_shift #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic             shift,
    input  logic             ser_in,
    input  logic [WIDTH-1:0] load_data,
    output logic             ser_out,
    output logic [WIDTH-1:0] par_nxt,
    output logic [CW-1:0]    cnt
);
    logic [WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_comb begin
        par_nxt = {ser_in, data_q[WIDTH-1:1]};
        data_d  = data_q;
        cnt_d   = cnt_q;
        if (clr) begin
            data_d = '0;
            cnt_d  = '0;
        end else if (load) begin
            data_d = load_data;
            cnt_d  = '0;
        end else if (shift) begin
            data_d = par_nxt;
            cnt_d  = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign ser_out = data_q[0];
    assign cnt     = cnt_q;
endmodule

// File: rtl/sram_scan_burst_ctrl.sv
// Serial-scan burst controller driving a single-port synchronous SRAM.
// Optional SRAM_SCAN_PARITY_EN: even parity per word, bad write words are dropped.
module sram_scan_burst_ctrl
    import sram_scan_pkg::*;
#(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    sram_scan_burst_ctrl_if.slave  bus
);
    localparam int unsigned HDR_LEN  = hdr_len(ADDR_W, CNT_W);
    localparam int unsigned ADDR_LSB = hdr_addr_lsb(CNT_W);
    localparam int unsigned W        = word_bits(DATA_W);
    localparam int unsigned IN_W     = max_u(HDR_LEN, W);
    localparam int unsigned IN_CW    = $clog2(IN_W + 1);
    localparam int unsigned OUT_CW   = $clog2(W + 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    left_q, left_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                wr_ok_q, wr_ok_d;
    logic                err_q, err_d;
    logic                en_q, en_d;
    logic                rd_pend_q, rd_pend_d;
    logic                out_valid_q, out_valid_d;

    logic                in_clr, in_shift;
    logic                out_clr, out_load, out_shift;
    logic [IN_W-1:0]     in_nxt;
    logic [IN_CW-1:0]    in_cnt;
    logic                in_ser_unused;
    logic [W-1:0]        out_nxt_unused;
    logic                out_ser;
    logic [OUT_CW-1:0]   out_cnt;
    logic [W-1:0]        out_load_data;
    logic [HDR_LEN-1:0]  hdr;
    logic [W-1:0]        word;
    logic                word_ok;
    logic                start;
    logic                ce, we, done, busy;

    sram_scan_shift #(.WIDTH(IN_W), .CW(IN_CW)) u_in_shift (
        .clk       (clk),
        .rst       (rst),
        .clr       (in_clr),
        .load      (1'b0),
        .shift     (in_shift),
        .ser_in    (bus.scan_in),
        .load_data ('0),
        .ser_out   (in_ser_unused),
        .par_nxt   (in_nxt),
        .cnt       (in_cnt)
    );

    sram_scan_shift #(.WIDTH(W), .CW(OUT_CW)) u_out_shift (
        .clk       (clk),
        .rst       (rst),
        .clr       (out_clr),
        .load      (out_load),
        .shift     (out_shift),
        .ser_in    (1'b0),
        .load_data (out_load_data),
        .ser_out   (out_ser),
        .par_nxt   (out_nxt_unused),
        .cnt       (out_cnt)
    );

    // Header and words are decoded from the post-shift value so the bit sampled this cycle is included.
    assign hdr  = in_nxt[IN_W-1 -: HDR_LEN];
    assign word = in_nxt[IN_W-1 -: W];

`ifdef SRAM_SCAN_PARITY_EN
    assign word_ok       = ~^word;
    assign out_load_data = {^bus.sram_dout, bus.sram_dout};
`else
    assign word_ok       = 1'b1;
    assign out_load_data = bus.sram_dout;
`endif

    assign start = (state_q == ST_IDLE) && bus.scan_en && !en_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        left_d      = left_q;
        wdata_d     = wdata_q;
        wr_ok_d     = wr_ok_q;
        err_d       = err_q;
        en_d        = bus.scan_en;
        rd_pend_d   = 1'b0;
        out_valid_d = out_valid_q;
        in_clr      = 1'b0;
        in_shift    = 1'b0;
        out_clr     = 1'b0;
        out_load    = 1'b0;
        out_shift   = 1'b0;
        ce          = 1'b0;
        we          = 1'b0;
        done        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                out_clr     = 1'b1;
                out_valid_d = 1'b0;
                if (start) begin
                    state_d  = ST_HDR;
                    in_shift = 1'b1;
                    err_d    = 1'b0;
                end else begin
                    in_clr = 1'b1;
                end
            end
            ST_HDR: begin
                if (!bus.scan_en) begin
                    state_d = ST_IDLE;
                    in_clr  = 1'b1;
                end else begin
                    in_shift = 1'b1;
                    if (in_cnt == IN_CW'(HDR_LEN - 1)) begin
                        in_clr  = 1'b1;
                        addr_d  = hdr[ADDR_LSB +: ADDR_W];
                        left_d  = hdr[HDR_CNT_LSB +: CNT_W];
                        state_d = hdr[HDR_RW_BIT] ? ST_WR_SHIFT : ST_RD_ISSUE;
                    end
                end
            end
            ST_WR_SHIFT: begin
                if (!bus.scan_en) begin
                    state_d = ST_IDLE;
                    in_clr  = 1'b1;
                end else begin
                    in_shift = 1'b1;
                    if (in_cnt == IN_CW'(W - 1)) begin
                        in_clr  = 1'b1;
                        wdata_d = word[DATA_W-1:0];
                        wr_ok_d = word_ok;
                        if (!word_ok) begin
                            err_d = 1'b1;
                        end
                        state_d = ST_WR_ISSUE;
                    end
                end
            end
            ST_WR_ISSUE: begin
                // The strobe is owed even when scan_en drops on this very cycle.
                ce     = wr_ok_q;
                we     = wr_ok_q;
                addr_d = addr_q + ADDR_W'(1);
                if (!bus.scan_en) begin
                    state_d = ST_IDLE;
                    in_clr  = 1'b1;
                end else if (left_q == '0) begin
                    state_d = ST_DONE;
                    in_clr  = 1'b1;
                end else begin
                    left_d   = left_q - CNT_W'(1);
                    in_shift = 1'b1;
                    state_d  = ST_WR_SHIFT;
                end
            end
            ST_RD_ISSUE: begin
                if (!bus.scan_en) begin
                    state_d = ST_IDLE;
                end else begin
                    ce        = 1'b1;
                    addr_d    = addr_q + ADDR_W'(1);
                    rd_pend_d = 1'b1;
                    state_d   = ST_RD_SHIFT;
                end
            end
            ST_RD_SHIFT: begin
                if (!bus.scan_en) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end else begin
                    out_load  = rd_pend_q;
                    out_shift = out_valid_q;
                    if (rd_pend_q) begin
                        out_valid_d = 1'b1;
                    end
                    // Issuing two bits early lands the next word right behind the current one.
                    if (out_valid_q && out_cnt == OUT_CW'(W - 2) && left_q != '0) begin
                        ce        = 1'b1;
                        addr_d    = addr_q + ADDR_W'(1);
                        left_d    = left_q - CNT_W'(1);
                        rd_pend_d = 1'b1;
                    end
                    if (out_valid_q && !rd_pend_q && out_cnt == OUT_CW'(W - 1)) begin
                        out_valid_d = 1'b0;
                        state_d     = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                in_clr  = 1'b1;
                out_clr = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q != ST_IDLE) || start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            left_q      <= '0;
            wdata_q     <= '0;
            wr_ok_q     <= 1'b0;
            err_q       <= 1'b0;
            en_q        <= 1'b0;
            rd_pend_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            left_q      <= left_d;
            wdata_q     <= wdata_d;
            wr_ok_q     <= wr_ok_d;
            err_q       <= err_d;
            en_q        <= en_d;
            rd_pend_q   <= rd_pend_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.scan_out       = out_valid_q & out_ser;
    assign bus.scan_out_valid = out_valid_q;
    assign bus.busy           = busy;
    assign bus.done           = done;
    assign bus.err            = err_q;
    assign bus.sram_ce        = ce;
    assign bus.sram_we        = we;
    assign bus.sram_addr      = addr_q;
    assign bus.sram_din       = wdata_q;
endmodule

// File: tb/tb_sram_scan_burst_ctrl.sv
// Directed bench for sram_scan_burst_ctrl: write/read bursts, wrap, abort, reset, parity.
module tb_sram_scan_burst_ctrl;
    localparam int unsigned AW = 12;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 4;
`ifdef SRAM_SCAN_PARITY_EN
    localparam int W = DW + 1;
`else
    localparam int W = DW;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sram_scan_burst_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    sram_scan_burst_ctrl #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DW-1:0] mem [0:4095];
    always @(posedge clk) begin
        if (bus.sram_ce) begin
            if (bus.sram_we) mem[bus.sram_addr] <= bus.sram_din;
            else             bus.sram_dout <= mem[bus.sram_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int            wr_cyc[$];
    logic [AW-1:0] wr_addr[$];
    logic [DW-1:0] wr_data[$];
    int            rd_cyc[$];
    logic [AW-1:0] rd_addr[$];
    int            done_cyc[$];
    logic          ob[$];
    int            ob_cyc[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.sram_ce && bus.sram_we) begin
                wr_cyc.push_back(cyc); wr_addr.push_back(bus.sram_addr); wr_data.push_back(bus.sram_din);
            end
            if (bus.sram_ce && !bus.sram_we) begin
                rd_cyc.push_back(cyc); rd_addr.push_back(bus.sram_addr);
            end
            if (bus.done) done_cyc.push_back(cyc);
            if (bus.scan_out_valid) begin
                ob.push_back(bus.scan_out); ob_cyc.push_back(cyc);
            end
        end
    end

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
        rd_cyc.delete(); rd_addr.delete(); done_cyc.delete();
        ob.delete(); ob_cyc.delete();
    endtask

    bit sq[$];

    task automatic push_bits(input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) sq.push_back(v[i]);
    endtask

    task automatic push_hdr(input bit rw, input logic [CW-1:0] cnt, input logic [AW-1:0] a);
        push_bits(32'(rw), 1);
        push_bits(32'(cnt), CW);
        push_bits(32'(a), AW);
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        push_bits(32'(d), DW);
`ifdef SRAM_SCAN_PARITY_EN
        push_bits(32'(^d), 1);
`endif
    endtask

    // Drives the queued bits one per cycle, then holds scan_en high for 'hold' cycles.
    task automatic send(input int hold, input bit drop, output int c0);
        c0 = 0;
        for (int i = 0; i < sq.size(); i++) begin
            @(posedge clk); #1;
            if (i == 0) c0 = cyc;
            bus.scan_en = 1'b1;
            bus.scan_in = sq[i];
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            bus.scan_in = 1'b0;
        end
        if (drop) begin
            @(posedge clk); #1;
            bus.scan_en = 1'b0;
        end
        sq.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_read(input string tag, input int k, input logic [DW-1:0] exp);
        logic [DW-1:0] d;
        d = '0;
        if (ob.size() >= (k + 1) * W) begin
            for (int j = 0; j < DW; j++) d[j] = ob[k * W + j];
            chk(tag, 32'(d), 32'(exp));
`ifdef SRAM_SCAN_PARITY_EN
            chk({tag, "_par"}, 32'(ob[k * W + DW]), 32'(^exp));
`endif
        end else begin
            chk({tag, "_bits"}, ob.size(), (k + 1) * W);
        end
    endtask

    task automatic chk_outputs_reset(input string pfx);
        chk({pfx, "_scan_out"}, 32'(bus.scan_out), 0);
        chk({pfx, "_valid"},    32'(bus.scan_out_valid), 0);
        chk({pfx, "_busy"},     32'(bus.busy), 0);
        chk({pfx, "_done"},     32'(bus.done), 0);
        chk({pfx, "_err"},      32'(bus.err), 0);
        chk({pfx, "_ce"},       32'(bus.sram_ce), 0);
        chk({pfx, "_we"},       32'(bus.sram_we), 0);
        chk({pfx, "_addr"},     32'(bus.sram_addr), 0);
        chk({pfx, "_din"},      32'(bus.sram_din), 0);
    endtask

    initial begin
        int c0;
        int h;
        logic [AW-1:0] ea [3];
        logic [DW-1:0] ed [3];

        bus.scan_en = 1'b0;
        bus.scan_in = 1'b0;
        #2 rst = 1'b1;
        #1 chk_outputs_reset("init");
        #20;
        @(posedge clk); #2 rst = 1'b0;
        idle(2);

        // Write burst of three words at 0x010.
        clear_mon();
        push_hdr(1'b1, 4'd2, 12'h010);
        push_word(8'hA5); push_word(8'h3C); push_word(8'hFF);
        send(2, 1'b1, c0);
        idle(4);
        ea = '{12'h010, 12'h011, 12'h012};
        ed = '{8'hA5, 8'h3C, 8'hFF};
        chk("wr_count", wr_addr.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (wr_addr.size() > i) begin
                chk($sformatf("wr_addr%0d", i), 32'(wr_addr[i]), 32'(ea[i]));
                chk($sformatf("wr_data%0d", i), 32'(wr_data[i]), 32'(ed[i]));
                chk($sformatf("wr_cyc%0d", i), wr_cyc[i] - c0, 16 + W * (i + 1) + 1);
            end
        end
        chk("wr_done_count", done_cyc.size(), 1);
        if (done_cyc.size() > 0) chk("wr_done_cyc", done_cyc[0] - c0, 16 + 3 * W + 2);
        chk("wr_busy_after", 32'(bus.busy), 0);

        // Read the same three words back.
        clear_mon();
        push_hdr(1'b0, 4'd2, 12'h010);
        send(3 + 3 * W, 1'b1, c0);
        idle(4);
        h = c0 + 16;
        chk("rd_strobes", rd_addr.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (rd_addr.size() > i) begin
                chk($sformatf("rd_addr%0d", i), 32'(rd_addr[i]), 32'(ea[i]));
                chk($sformatf("rd_cyc%0d", i), rd_cyc[i] - h, 1 + i * W);
            end
        end
        chk("rd_bits", ob.size(), 3 * W);
        if (ob.size() > 0) chk("rd_first_cyc", ob_cyc[0] - h, 3);
        if (ob.size() == 3 * W) chk("rd_last_cyc", ob_cyc[3 * W - 1] - h, 2 + 3 * W);
        chk_read("rd_w0", 0, 8'hA5);
        chk_read("rd_w1", 1, 8'h3C);
        chk_read("rd_w2", 2, 8'hFF);
        chk("rd_done_count", done_cyc.size(), 1);
        if (done_cyc.size() > 0) chk("rd_done_cyc", done_cyc[0] - h, 3 + 3 * W);

        // Address wrap from 0xFFF to 0x000.
        clear_mon();
        push_hdr(1'b1, 4'd1, 12'hFFF);
        push_word(8'h5A); push_word(8'h81);
        send(2, 1'b1, c0);
        idle(4);
        chk("wrap_count", wr_addr.size(), 2);
        if (wr_addr.size() >= 2) begin
            chk("wrap_addr0", 32'(wr_addr[0]), 32'h0FFF);
            chk("wrap_addr1", 32'(wr_addr[1]), 32'h0000);
            chk("wrap_data0", 32'(wr_data[0]), 32'h5A);
            chk("wrap_data1", 32'(wr_data[1]), 32'h81);
        end
        chk("wrap_done", done_cyc.size(), 1);

        // Abort: scan_en drops on the first word's WR_ISSUE cycle of a 4-word burst.
        clear_mon();
        push_hdr(1'b1, 4'd3, 12'h100);
        push_word(8'h11);
        send(0, 1'b1, c0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_busy", 32'(bus.busy), 0);
        idle(6);
        chk("abort_strobes", wr_addr.size(), 1);
        if (wr_addr.size() > 0) begin
            chk("abort_addr", 32'(wr_addr[0]), 32'h100);
            chk("abort_data", 32'(wr_data[0]), 32'h11);
            chk("abort_cyc", wr_cyc[0] - c0, 16 + W + 1);
        end
        chk("abort_no_done", done_cyc.size(), 0);

        // Reset in the middle of a read, then a clean read across the wrap.
        clear_mon();
        push_hdr(1'b0, 4'd2, 12'h010);
        send(8, 1'b0, c0);
        #3;
        chk("rst_pre_valid", 32'(bus.scan_out_valid), 1);
        chk("rst_pre_addr", 32'(bus.sram_addr), 32'h011);
        rst = 1'b1;
        bus.scan_en = 1'b0;
        #1 chk_outputs_reset("rst_mid");
        @(posedge clk); @(posedge clk); #2 rst = 1'b0;
        idle(2);
        clear_mon();
        push_hdr(1'b0, 4'd1, 12'hFFF);
        send(3 + 2 * W, 1'b1, c0);
        idle(4);
        chk("post_rst_strobes", rd_addr.size(), 2);
        if (rd_addr.size() >= 2) begin
            chk("post_rst_raddr0", 32'(rd_addr[0]), 32'hFFF);
            chk("post_rst_raddr1", 32'(rd_addr[1]), 32'h000);
        end
        if (ob.size() > 0) chk("post_rst_first", ob_cyc[0] - c0, 16 + 3);
        chk_read("post_rst_w0", 0, 8'h5A);
        chk_read("post_rst_w1", 1, 8'h81);
        chk("post_rst_done", done_cyc.size(), 1);
        chk("post_rst_err", 32'(bus.err), 0);

`ifdef SRAM_SCAN_PARITY_EN
        // Bad parity on 0x01 suppresses the strobe and sets err until the next frame.
        clear_mon();
        push_hdr(1'b1, 4'd0, 12'h200);
        push_bits(32'h01, 8);
        push_bits(32'h0, 1);
        send(2, 1'b1, c0);
        idle(3);
        chk("par_no_strobe", wr_addr.size(), 0);
        chk("par_err_set", 32'(bus.err), 1);
        clear_mon();
        push_hdr(1'b0, 4'd0, 12'h010);
        send(3 + W, 1'b1, c0);
        idle(3);
        chk("par_err_clear", 32'(bus.err), 0);
        chk_read("par_rd_w0", 0, 8'hA5);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
